// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath word width and sequencer FSM encoding.
package alu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/multiword_add_sequencer_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a lookahead carry unit.
module multiword_add_sequencer_cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] sum_o,
  output logic        c_o,
  output logic        p_o,
  output logic        g_o
);

  logic [15:0] p, g, cb;
  logic [3:0]  gp, gg;
  logic [4:0]  cg;

  always_comb begin
    p  = a_i ^ b_i;
    g  = a_i & b_i;
    gp = '1;
    gg = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        gp[k] = gp[k] & p[4*k+j];
      end
    end

    cg[0] = c_i;
    cg[1] = gg[0] | (gp[0] & c_i);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_i);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

    cb = '0;
    for (int k = 0; k < 4; k++) begin
      cb[4*k] = cg[k];
      for (int j = 1; j < 4; j++) begin
        cb[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & cb[4*k+j-1]);
      end
    end

    sum_o = p ^ cb;
    c_o   = cg[4];
    p_o   = &gp;
    g_o   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract: one 16-bit word per cycle, LSW first, through a shared CLA.
module multiword_add_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_c_out,
  output logic                  out_ovf
);

  localparam int unsigned OpW  = WORD_W * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [OpW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d, valid_q, valid_d;

  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_c, cla_p_unused, cla_g_unused;
  logic              accept, last_word, handshake;

  assign add_a     = a_q[WORD_W*idx_q +: WORD_W];
  assign add_b     = b_q[WORD_W*idx_q +: WORD_W];
  assign accept    = in_valid && (state_q == StIdle);
  assign last_word = (idx_q == LastIdx);
  assign handshake = valid_q && out_ready;

  multiword_add_sequencer_cla16 u_cla (
    .a_i   (add_a),
    .b_i   (add_b),
    .c_i   (carry_q),
    .sum_o (add_sum),
    .c_o   (add_c),
    .p_o   (cla_p_unused),
    .g_o   (cla_g_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // The result is offered one cycle after DONE is entered, so out_valid is registered.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (last_word) state_d = StDone;
      StDone: begin
        valid_d = !handshake;
        if (handshake) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = valid_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = in_a;
      b_d     = in_sub ? ~in_b : in_b;
      carry_d = in_sub;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[WORD_W*idx_q +: WORD_W] = add_sum;
      carry_d = add_c;
      idx_d   = last_word ? '0 : idx_q + IdxW'(1);
      if (last_word) begin
        c_out_d = add_c;
        ovf_d   = (a_q[OpW-1] == b_q[OpW-1]) && (add_sum[WORD_W-1] != a_q[OpW-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_c_out = c_out_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer with WORDS=4.
module tb_multiword_add_sequencer;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, out_c_out, out_ovf;
  logic [W-1:0] out_sum;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  multiword_add_sequencer #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c_out (out_c_out),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         e;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.sum = full[W-1:0];
    e.c   = full[W];
    e.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Offer an operand set, push its expected result, return #1 after the accept edge.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic tmo);
    int n = 0;
    sb.push_back(model(a, b, sub));
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tmo = !in_ready;
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid with out_ready high, capture outputs, complete the handshake.
  task automatic get_result(output logic [W-1:0] s, output logic c, output logic v,
                            output int lat, output logic tmo);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tmo = !out_valid;
    lat = cyc - accept_cyc;
    s = out_sum; c = out_c_out; v = out_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_c_out !== 1'b0 ||
        out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b ovf=%b required rdy=1 vld=0 sum=0 c=0 ovf=0",
               in_ready, out_valid, out_sum, out_c_out, out_ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [W-1:0] va[4], vb[4], s;
    logic         c, v, t1, t2;
    int           lat;
    exp_t         e;
    va[0] = 64'h1;                  vb[0] = 64'h2;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;
    va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 4; i++) begin
      send_op(va[i], vb[i], 1'b0, t1);
      get_result(s, c, v, lat, t2);
      e = sb.pop_front();
      checks++;
      if (t1 || t2) begin
        failures++; $display("FAIL add%0d timeout: in=%b out=%b required 0 0", i, t1, t2);
      end
      checks++;
      if (s !== e.sum || c !== e.c || v !== e.ovf) begin
        failures++;
        $display("FAIL add%0d: got sum=%h c=%b ovf=%b required sum=%h c=%b ovf=%b",
                 i, s, c, v, e.sum, e.c, e.ovf);
      end
      checks++;
      if (lat !== 5) begin
        failures++; $display("FAIL add%0d latency: got %0d required 5", i, lat);
      end
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] va[3], vb[3], s;
    logic         c, v, t1, t2;
    int           lat;
    exp_t         e;
    va[0] = 64'd5;                  vb[0] = 64'd7;
    va[1] = 64'd7;                  vb[1] = 64'd5;
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h1;
    for (int i = 0; i < 3; i++) begin
      send_op(va[i], vb[i], 1'b1, t1);
      get_result(s, c, v, lat, t2);
      e = sb.pop_front();
      checks++;
      if (t1 || t2 || s !== e.sum || c !== e.c || v !== e.ovf) begin
        failures++;
        $display("FAIL sub%0d: got sum=%h c=%b ovf=%b tmo=%b%b required sum=%h c=%b ovf=%b",
                 i, s, c, v, t1, t2, e.sum, e.c, e.ovf);
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [W-1:0] s;
    logic         c, v, t1, t2;
    int           lat, n;
    exp_t         e;
    out_ready = 1'b0;
    send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, t1);
    e = sb[0];
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (t1 || !out_valid) begin
      failures++; $display("FAIL bp_wait: got valid=%b required 1", out_valid);
    end
    in_a = 64'h8000_0000_0000_0000; in_b = 64'h1; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum || out_c_out !== e.c ||
          out_ovf !== e.ovf) begin
        failures++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h required vld=1 rdy=0 sum=%h",
                 i, out_valid, in_ready, out_sum, e.sum);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    void'(sb.pop_front());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    sb.push_back(model(in_a, in_b, in_sub));
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_second_accept: got rdy=%b required 0", in_ready);
    end
    get_result(s, c, v, lat, t2);
    e = sb.pop_front();
    checks++;
    if (t2 || s !== e.sum || c !== e.c || v !== e.ovf || lat !== 5) begin
      failures++;
      $display("FAIL bp_second: got sum=%h c=%b ovf=%b lat=%0d required sum=%h c=%b ovf=%b lat=5",
               s, c, v, lat, e.sum, e.c, e.ovf);
    end
  endtask

  task automatic test_reset_midrun;
    logic [W-1:0] s;
    logic         c, v, t1, t2;
    int           lat;
    exp_t         e;
    send_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, t1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_c_out !== 1'b0 ||
        out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: rdy=%b vld=%b sum=%h c=%b ovf=%b required rdy=1 vld=0 sum=0",
               in_ready, out_valid, out_sum, out_c_out, out_ovf);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(64'd3, 64'd4, 1'b0, t1);
    get_result(s, c, v, lat, t2);
    e = sb.pop_front();
    checks++;
    if (t1 || t2 || s !== 64'd7 || s !== e.sum || c !== 1'b0 || v !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op: got sum=%h c=%b ovf=%b required sum=7 c=0 ovf=0", s, c, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b, s;
    logic         sub, c, v, t1, t2;
    int           lat;
    exp_t         e;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sub = 1'($urandom_range(0, 1));
      send_op(a, b, sub, t1);
      get_result(s, c, v, lat, t2);
      e = sb.pop_front();
      checks++;
      if (t1 || t2 || s !== e.sum || c !== e.c || v !== e.ovf || lat !== 5) begin
        failures++;
        $display("FAIL b2b%0d: got sum=%h c=%b ovf=%b lat=%0d required sum=%h c=%b ovf=%b lat=5",
                 i, s, c, v, lat, e.sum, e.c, e.ovf);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_pressure();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
